// File: rtl/counter.sv
// Train-sensor edge counter: synchronizes y, detects rising edges and
// keeps a modulo (MAX_COUNT+1) count on present_state.
module counter #(
  parameter int MAX_COUNT   = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       y,
  output logic [3:0] present_state
);

  localparam logic [3:0] MAX_VAL = 4'(MAX_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   y_sync;
  logic                   y_prev;
  logic                   rise;
  logic [3:0]             count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], y};
    end
  end

  assign y_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_prev <= 1'b0;
    end else begin
      y_prev <= y_sync;
    end
  end

  // y_prev resets low, so a level already high at release counts once
  assign rise = y_sync & ~y_prev;

  always_comb begin
    count_d = present_state;
    if (rise) begin
      if (present_state == MAX_VAL) begin
        count_d = '0;
      end else begin
        count_d = present_state + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      present_state <= '0;
    end else begin
      present_state <= count_d;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Bench for counter: directed scenarios plus random y/reset traffic,
// both checked against a sample-history model of the counting rules.
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       y;
  logic [3:0] ps15;
  logic [3:0] ps9;

  int n_cmp;
  int n_bad;

  counter #(.MAX_COUNT(15), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .y(y),
    .present_state(ps15)
  );

  counter #(.MAX_COUNT(9), .SYNC_STAGES(2)) dut9 (
    .clk(clk),
    .rst_n(rst_n),
    .y(y),
    .present_state(ps9)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: y as seen at each clock edge; a low->high step between two
  // samples is a rise, and it shows up on the count two edges later.
  bit prev_s;
  bit rq[$];
  int matured;

  initial begin
    prev_s  = 1'b0;
    matured = 0;
  end

  always @(negedge rst_n) begin
    prev_s  = 1'b0;
    matured = 0;
    rq.delete();
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      rq.push_back(y && !prev_s);
      prev_s = y;
      if (rq.size() > 2) matured += int'(rq.pop_front());
    end
  end

  function automatic int exp_count(input int maxc);
    return matured % (maxc + 1);
  endfunction

  always @(negedge clk) begin
    check("run15", int'(ps15), exp_count(15));
    check("run9", int'(ps9), exp_count(9));
  end

  task automatic pulse(input int hi, input int lo);
    @(negedge clk);
    y = 1'b1;
    repeat (hi) @(negedge clk);
    y = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  int base;
  int d;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    y     = 1'b0;

    // reset held with y toggling
    #25 y = 1'b1;
    #30 y = 1'b0;
    #20 y = 1'b1;
    #20 y = 1'b0;
    #4 check("rst_hold", int'(ps15), 0);
    #1 rst_n = 1'b1;

    // y toggles every 100ns, five rises
    for (int i = 0; i < 10; i++) begin
      #100 y = ~y;
    end
    #100 check("basic5", int'(ps15), 5);
    check("basic5_9", int'(ps9), 5);

    // asynchronous reset between edges
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1 check("async_rst", int'(ps15), 0);
    check("async_rst9", int'(ps9), 0);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // latency: rise 5ns before edge k
    @(posedge clk);
    base = int'(ps15);
    #15 y = 1'b1;
    @(posedge clk);
    #1 check("lat_k", int'(ps15), base);
    @(posedge clk);
    #1 check("lat_k1", int'(ps15), base);
    @(posedge clk);
    #1 check("lat_k2", int'(ps15), base + 1);
    @(posedge clk);
    #1 check("lat_k3", int'(ps15), base + 1);
    @(negedge clk);
    y = 1'b0;
    repeat (3) @(negedge clk);

    // wrap: 16 rises
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      pulse(3, 3);
      check($sformatf("wrap15_%0d", i), int'(ps15), i % 16);
      check($sformatf("wrap9_%0d", i), int'(ps9), i % 10);
    end

    // long high then low, then a 1ns glitch
    base = int'(ps15);
    pulse(50, 10);
    check("hold50", int'(ps15), (base + 1) % 16);
    base = int'(ps15);
    @(posedge clk);
    #5 y = 1'b1;
    #1 y = 1'b0;
    repeat (5) @(negedge clk);
    d = (int'(ps15) - base + 16) % 16;
    check("glitch_le1", int'(d <= 1), 1);

    // mid-run reset with a rise in the synchronizer
    do_reset();
    repeat (7) pulse(3, 3);
    check("mid_7", int'(ps15), 7);
    @(negedge clk);
    y = 1'b1;
    @(posedge clk);
    #1 y = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("mid_rst", int'(ps15), 0);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_stay0", int'(ps15), 0);
    pulse(3, 3);
    check("mid_next", int'(ps15), 1);

    // y high across reset release counts once
    @(negedge clk);
    y = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    check("high_rel", int'(ps15), 1);
    y = 1'b0;
    repeat (3) @(negedge clk);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #($urandom_range(1, 8));
      y = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        #1 y = ~y;
      end
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
